axi_stream_strip_header: RTL and testbench

//  Receive-side counterpart of header insertion. Removes strip_cnt leading bytes from each AXI-Stream packet.

---
 rtl/axis_strip_pkg.sv | 30 +++
 rtl/axis_byte_realign.sv | 28 ++
 rtl/axi_stream_strip_header.sv | 198 +++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_strip_pkg.sv
// Shared types and helpers for the AXI-Stream header stripper.
// Masks are MSB-first: bit W-1 of a keep vector is byte 0.
package axis_strip_pkg;

   localparam int MAX_BYTES = 64;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   typedef logic [MAX_BYTES-1:0] mask_t;

   // Top n bits of a w-bit keep vector set.
   function automatic mask_t keep_from_cnt(input int n, input int w);
      mask_t m;
      m = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         if (i < w && i >= w - n) m[i] = 1'b1;
      return m;
   endfunction

   function automatic int cnt_from_keep(input mask_t k, input int w);
      int c;
      c = 0;
      for (int i = 0; i < MAX_BYTES; i++)
         if (i < w && k[i]) c = c + 1;
      return c;
   endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Merges a left-aligned residue with an incoming beat and
// returns the leftover bytes plus byte counts.
module axis_byte_realign
   import axis_strip_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic [DATA_WD-1:0]      res_data,
   input  logic [BYTE_CNT_WD-1:0]  res_cnt,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   output logic [DATA_WD-1:0]      merged,
   output logic [DATA_WD-1:0]      new_res,
   output logic [BYTE_CNT_WD:0]    beat_cnt,
   output logic [BYTE_CNT_WD:0]    total_cnt
);

   always_comb begin
      beat_cnt  = (BYTE_CNT_WD+1)'(cnt_from_keep(mask_t'(keep_in), DATA_BYTE_WD));
      total_cnt = beat_cnt + {1'b0, res_cnt};
      merged    = res_data | (data_in >> (8 * int'(res_cnt)));
      // Shift of a full width clears new_res when there is no residue.
      new_res   = data_in << (8 * (DATA_BYTE_WD - int'(res_cnt)));
   end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet header from an AXI-Stream, emits it on a
// side port and re-aligns the remaining payload to byte 0.
module axi_stream_strip_header
   import axis_strip_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   output logic                    valid_hdr,
   output logic [DATA_WD-1:0]      data_hdr,
   output logic [DATA_BYTE_WD-1:0] keep_hdr,
   input  logic                    ready_hdr,
   output logic                    err_short
);

   localparam int W = DATA_BYTE_WD;

   logic [1:0]             state_q, state_d;
   logic [DATA_WD-1:0]     res_q, res_d;
   logic [BYTE_CNT_WD-1:0] rcnt_q, rcnt_d;
   logic                   ovld_q, ovld_d;
   logic [DATA_WD-1:0]     odata_q, odata_d;
   logic [W-1:0]           okeep_q, okeep_d;
   logic                   olast_q, olast_d;
   logic                   hvld_q, hvld_d;
   logic [DATA_WD-1:0]     hdata_q, hdata_d;
   logic [W-1:0]           hkeep_q, hkeep_d;
   logic                   err_q, err_d;

   logic [DATA_WD-1:0]     rl_res, merged, new_res;
   logic [BYTE_CNT_WD-1:0] rl_cnt;
   logic [BYTE_CNT_WD:0]   beat_cnt, total_cnt;
   logic                   out_free, s_nz, acc;
   int                     s, v, t;

   function automatic logic [W-1:0] kmask(input int n);
      return W'(keep_from_cnt(n, W));
   endfunction

   function automatic logic [DATA_WD-1:0] bmask(input logic [W-1:0] k);
      logic [DATA_WD-1:0] m;
      for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   // In IDLE the beat is realigned against an empty residue.
   assign rl_res = (state_q == IDLE) ? '0 : res_q;
   assign rl_cnt = (state_q == IDLE) ? '0 : rcnt_q;

   axis_byte_realign #(
      .DATA_WD      (DATA_WD),
      .DATA_BYTE_WD (DATA_BYTE_WD),
      .BYTE_CNT_WD  (BYTE_CNT_WD)
   ) u_realign (
      .res_data  (rl_res),
      .res_cnt   (rl_cnt),
      .data_in   (data_in),
      .keep_in   (keep_in),
      .merged    (merged),
      .new_res   (new_res),
      .beat_cnt  (beat_cnt),
      .total_cnt (total_cnt)
   );

   assign out_free = !ovld_q || ready_out;
   assign s_nz     = strip_cnt != '0;
   assign ready_in = out_free && state_q != FLUSH
                  && !(state_q == IDLE && s_nz && hvld_q && !ready_hdr);
   assign acc      = valid_in && ready_in;
   assign s        = int'(strip_cnt);
   assign v        = int'(beat_cnt);
   assign t        = int'(total_cnt);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      rcnt_d  = rcnt_q;
      ovld_d  = ovld_q && !ready_out;
      odata_d = odata_q;
      okeep_d = okeep_q;
      olast_d = olast_q;
      hvld_d  = hvld_q && !ready_hdr;
      hdata_d = hdata_q;
      hkeep_d = hkeep_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: if (acc) begin
            if (s_nz) begin
               hvld_d  = 1'b1;
               hkeep_d = kmask(s);
               hdata_d = data_in & bmask(kmask(s));
            end
            if (last_in && v <= s) begin
               err_d = 1'b1;
            end else if (last_in) begin
               ovld_d  = 1'b1;
               okeep_d = kmask(v - s);
               odata_d = (data_in << (8 * s)) & bmask(kmask(v - s));
               olast_d = 1'b1;
            end else if (s_nz) begin
               res_d   = data_in << (8 * s);
               rcnt_d  = BYTE_CNT_WD'(W - s);
               state_d = STREAM;
            end else begin
               ovld_d  = 1'b1;
               okeep_d = '1;
               odata_d = merged;
               olast_d = 1'b0;
               res_d   = '0;
               rcnt_d  = '0;
               state_d = STREAM;
            end
         end
         STREAM: if (acc) begin
            ovld_d = 1'b1;
            if (last_in && t <= W) begin
               okeep_d = kmask(t);
               odata_d = merged & bmask(kmask(t));
               olast_d = 1'b1;
               res_d   = '0;
               rcnt_d  = '0;
               state_d = IDLE;
            end else begin
               okeep_d = '1;
               odata_d = merged;
               olast_d = 1'b0;
               res_d   = new_res;
               if (last_in) begin
                  rcnt_d  = BYTE_CNT_WD'(t - W);
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: if (out_free) begin
            ovld_d  = 1'b1;
            okeep_d = kmask(int'(rcnt_q));
            odata_d = res_q & bmask(kmask(int'(rcnt_q)));
            olast_d = 1'b1;
            res_d   = '0;
            rcnt_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
         rcnt_q  <= '0;
         ovld_q  <= 1'b0;
         odata_q <= '0;
         okeep_q <= '0;
         olast_q <= 1'b0;
         hvld_q  <= 1'b0;
         hdata_q <= '0;
         hkeep_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         rcnt_q  <= rcnt_d;
         ovld_q  <= ovld_d;
         odata_q <= odata_d;
         okeep_q <= okeep_d;
         olast_q <= olast_d;
         hvld_q  <= hvld_d;
         hdata_q <= hdata_d;
         hkeep_q <= hkeep_d;
         err_q   <= err_d;
      end
   end

   assign valid_out = ovld_q;
   assign data_out  = odata_q;
   assign keep_out  = okeep_q;
   assign last_out  = olast_q;
   assign valid_hdr = hvld_q;
   assign data_hdr  = hdata_q;
   assign keep_hdr  = hkeep_q;
   assign err_short = err_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed testbench for axi_stream_strip_header (DATA_WD=32).
// Transfers are logged at the falling edge and checked per scenario.
module tb_axi_stream_strip_header;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] data_in = '0;
   logic [3:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic [1:0]  strip_cnt = '0;
   logic        ready_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        ready_out = 1'b1;
   logic        valid_hdr;
   logic [31:0] data_hdr;
   logic [3:0]  keep_hdr;
   logic        ready_hdr = 1'b1;
   logic        err_short;

   int n_checks = 0;
   int n_fail = 0;

   logic [36:0] oq[$];
   logic [35:0] hq[$];
   int          err_cyc = 0;
   int          hv_cyc = 0;

   always #5 clk = ~clk;

   axi_stream_strip_header #(.DATA_WD(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .keep_in   (keep_in),
      .last_in   (last_in),
      .strip_cnt (strip_cnt),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .keep_out  (keep_out),
      .last_out  (last_out),
      .ready_out (ready_out),
      .valid_hdr (valid_hdr),
      .data_hdr  (data_hdr),
      .keep_hdr  (keep_hdr),
      .ready_hdr (ready_hdr),
      .err_short (err_short)
   );

   // Handshake inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_out && ready_out) oq.push_back({data_out, keep_out, last_out});
         if (valid_hdr && ready_hdr) hq.push_back({data_hdr, keep_hdr});
         if (err_short) err_cyc = err_cyc + 1;
         if (valid_hdr) hv_cyc = hv_cyc + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [36:0] oget(input int i);
      return (i < oq.size()) ? oq[i] : '1;
   endfunction

   function automatic logic [35:0] hget(input int i);
      return (i < hq.size()) ? hq[i] : '1;
   endfunction

   task automatic drive(input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic [1:0] s);
      valid_in  = 1'b1;
      data_in   = d;
      keep_in   = k;
      last_in   = l;
      strip_cnt = s;
   endtask

   task automatic wait_acc(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (ready_in) done = 1'b1;
      end
      if (done) begin
         @(posedge clk);
         #1;
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: beat not accepted within 50 cycles", nm);
      end
      valid_in = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic [1:0] s, input string nm);
      drive(d, k, l, s);
      wait_acc(nm);
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({valid_out, data_out, keep_out, last_out} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_out: got %h/%h/%b/%b want all 0", data_out, keep_out, valid_out, last_out);
      end
      n_checks++;
      if ({valid_hdr, data_hdr, keep_hdr} !== 37'd0) begin
         n_fail++;
         $display("FAIL reset_hdr: got %h/%h/%b want all 0", data_hdr, keep_hdr, valid_hdr);
      end
      n_checks++;
      if (err_short !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b want 0", err_short);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_s1_flush();
      int o0, h0;
      o0 = oq.size();
      h0 = hq.size();
      send(32'hAABBCCDD, 4'hF, 1'b0, 2'd1, "s1_b0");
      send(32'h11223344, 4'hF, 1'b1, 2'd1, "s1_b1");
      @(negedge clk);
      n_checks++;
      if (ready_in !== 1'b0) begin
         n_fail++;
         $display("FAIL s1_flush_ready: ready_in=%b want 0", ready_in);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (oq.size() - o0 != 2) begin
         n_fail++;
         $display("FAIL s1_out_cnt: got %0d beats want 2", oq.size() - o0);
      end
      n_checks++;
      if (oget(o0) !== {32'hBBCCDD11, 4'hF, 1'b0}) begin
         n_fail++;
         $display("FAIL s1_out0: got %h want %h", oget(o0), {32'hBBCCDD11, 4'hF, 1'b0});
      end
      n_checks++;
      if (oget(o0 + 1) !== {32'h22334400, 4'hE, 1'b1}) begin
         n_fail++;
         $display("FAIL s1_out1: got %h want %h", oget(o0 + 1), {32'h22334400, 4'hE, 1'b1});
      end
      n_checks++;
      if (hq.size() - h0 != 1 || hget(h0) !== {32'hAA000000, 4'h8}) begin
         n_fail++;
         $display("FAIL s1_hdr: got %h (n=%0d) want %h", hget(h0), hq.size() - h0, {32'hAA000000, 4'h8});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_s2_fold();
      int o0, h0;
      o0 = oq.size();
      h0 = hq.size();
      send(32'hAABBCCDD, 4'hF, 1'b0, 2'd2, "s2_b0");
      send(32'h11220000, 4'hC, 1'b1, 2'd2, "s2_b1");
      repeat (4) @(negedge clk);
      n_checks++;
      if (oq.size() - o0 != 1 || oget(o0) !== {32'hCCDD1122, 4'hF, 1'b1}) begin
         n_fail++;
         $display("FAIL s2_out: got %h (n=%0d) want %h", oget(o0), oq.size() - o0, {32'hCCDD1122, 4'hF, 1'b1});
      end
      n_checks++;
      if (hq.size() - h0 != 1 || hget(h0) !== {32'hAABB0000, 4'hC}) begin
         n_fail++;
         $display("FAIL s2_hdr: got %h want %h", hget(h0), {32'hAABB0000, 4'hC});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_short();
      int o0, h0, e0;
      o0 = oq.size();
      h0 = hq.size();
      e0 = err_cyc;
      send(32'hAABBCCDD, 4'hE, 1'b1, 2'd3, "short_b0");
      @(negedge clk);
      n_checks++;
      if (err_short !== 1'b1 || valid_hdr !== 1'b1 || data_hdr !== 32'hAABBCC00 || keep_hdr !== 4'hE) begin
         n_fail++;
         $display("FAIL short_pulse: err=%b hv=%b hdr=%h/%h want 1 1 AABBCC00/E", err_short, valid_hdr, data_hdr, keep_hdr);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (err_cyc - e0 != 1) begin
         n_fail++;
         $display("FAIL short_err_width: got %0d cycles want 1", err_cyc - e0);
      end
      n_checks++;
      if (oq.size() - o0 != 0) begin
         n_fail++;
         $display("FAIL short_no_payload: got %0d beats want 0", oq.size() - o0);
      end
      n_checks++;
      if (hq.size() - h0 != 1 || hget(h0) !== {32'hAABBCC00, 4'hE}) begin
         n_fail++;
         $display("FAIL short_hdr: got %h want %h", hget(h0), {32'hAABBCC00, 4'hE});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_s0_pass();
      logic [31:0] beats [3];
      int o0, h0, hv0;
      beats[0] = 32'h01020304;
      beats[1] = 32'h05060708;
      beats[2] = 32'h090A0B0C;
      o0 = oq.size();
      h0 = hq.size();
      hv0 = hv_cyc;
      for (int i = 0; i < 3; i++) begin
         send(beats[i], 4'hF, (i == 2), 2'd0, "s0_beat");
         @(negedge clk);
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== beats[i] || keep_out !== 4'hF || last_out !== (i == 2)) begin
            n_fail++;
            $display("FAIL s0_latency%0d: got v=%b %h/%h l=%b want 1 %h/F l=%0d", i, valid_out, data_out, keep_out, last_out, beats[i], (i == 2));
         end
         @(posedge clk);
         #1;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (oq.size() - o0 != 3) begin
         n_fail++;
         $display("FAIL s0_out_cnt: got %0d want 3", oq.size() - o0);
      end
      n_checks++;
      if (hv_cyc - hv0 != 0 || hq.size() - h0 != 0) begin
         n_fail++;
         $display("FAIL s0_no_hdr: valid_hdr cycles %0d want 0", hv_cyc - hv0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      int o0, h0;
      o0 = oq.size();
      h0 = hq.size();
      ready_hdr = 1'b0;
      ready_out = 1'b0;
      send(32'hAABBCCDD, 4'hF, 1'b0, 2'd1, "st_b0");
      send(32'h11223344, 4'hF, 1'b0, 2'd1, "st_b1");
      drive(32'h55667788, 4'hF, 1'b1, 2'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== 32'hBBCCDD11 || keep_out !== 4'hF) begin
            n_fail++;
            $display("FAIL st_hold%0d: got v=%b %h/%h want 1 BBCCDD11/F", i, valid_out, data_out, keep_out);
         end
         n_checks++;
         if (ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL st_ready%0d: ready_in=%b want 0", i, ready_in);
         end
      end
      @(posedge clk);
      #1;
      ready_out = 1'b1;
      wait_acc("st_b2");
      repeat (4) @(negedge clk);
      n_checks++;
      if (valid_hdr !== 1'b1 || data_hdr !== 32'hAA000000) begin
         n_fail++;
         $display("FAIL st_hdr_held: v=%b %h want 1 AA000000", valid_hdr, data_hdr);
      end
      @(posedge clk);
      #1;
      drive(32'h99887766, 4'hF, 1'b1, 2'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL st_hdr_block%0d: ready_in=%b want 0", i, ready_in);
         end
      end
      @(posedge clk);
      #1;
      ready_hdr = 1'b1;
      wait_acc("st_p2");
      repeat (4) @(negedge clk);
      n_checks++;
      if (oq.size() - o0 != 4) begin
         n_fail++;
         $display("FAIL st_out_cnt: got %0d want 4", oq.size() - o0);
      end
      n_checks++;
      if (oget(o0) !== {32'hBBCCDD11, 4'hF, 1'b0} || oget(o0 + 1) !== {32'h22334455, 4'hF, 1'b0}) begin
         n_fail++;
         $display("FAIL st_out01: got %h %h want BBCCDD11F0 22334455F0", oget(o0), oget(o0 + 1));
      end
      n_checks++;
      if (oget(o0 + 2) !== {32'h66778800, 4'hE, 1'b1} || oget(o0 + 3) !== {32'h88776600, 4'hE, 1'b1}) begin
         n_fail++;
         $display("FAIL st_out23: got %h %h want 66778800E1 88776600E1", oget(o0 + 2), oget(o0 + 3));
      end
      n_checks++;
      if (hq.size() - h0 != 2 || hget(h0) !== {32'hAA000000, 4'h8} || hget(h0 + 1) !== {32'h99000000, 4'h8}) begin
         n_fail++;
         $display("FAIL st_hdrs: got %h %h (n=%0d) want AA0000008 990000008", hget(h0), hget(h0 + 1), hq.size() - h0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int o0, h0;
      o0 = oq.size();
      h0 = hq.size();
      send(32'h11223344, 4'hF, 1'b1, 2'd1, "b2b_p0");
      send(32'h55667788, 4'hF, 1'b0, 2'd2, "b2b_p1b0");
      send(32'h99AABBCC, 4'h8, 1'b1, 2'd2, "b2b_p1b1");
      repeat (4) @(negedge clk);
      n_checks++;
      if (oq.size() - o0 != 2 || oget(o0) !== {32'h22334400, 4'hE, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_out0: got %h (n=%0d) want 22334400E1", oget(o0), oq.size() - o0);
      end
      n_checks++;
      if (oget(o0 + 1) !== {32'h77889900, 4'hE, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_out1: got %h want 77889900E1", oget(o0 + 1));
      end
      n_checks++;
      if (hq.size() - h0 != 2 || hget(h0) !== {32'h11000000, 4'h8} || hget(h0 + 1) !== {32'h55660000, 4'hC}) begin
         n_fail++;
         $display("FAIL b2b_hdrs: got %h %h want 110000008 55660000C", hget(h0), hget(h0 + 1));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_flush();
      int o0, h0;
      ready_out = 1'b0;
      send(32'hAABBCCDD, 4'hF, 1'b0, 2'd1, "rf_b0");
      send(32'h11223344, 4'hF, 1'b1, 2'd1, "rf_b1");
      @(negedge clk);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 32'hBBCCDD11 || ready_in !== 1'b0) begin
         n_fail++;
         $display("FAIL rf_in_flush: v=%b %h rdy=%b want 1 BBCCDD11 0", valid_out, data_out, ready_in);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({valid_out, data_out, keep_out, last_out} !== 38'd0) begin
         n_fail++;
         $display("FAIL rf_async_out: got v=%b %h/%h l=%b want all 0", valid_out, data_out, keep_out, last_out);
      end
      n_checks++;
      if ({valid_hdr, data_hdr, keep_hdr, err_short} !== 38'd0) begin
         n_fail++;
         $display("FAIL rf_async_hdr: got v=%b %h/%h e=%b want all 0", valid_hdr, data_hdr, keep_hdr, err_short);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ready_out = 1'b1;
      @(posedge clk);
      #1;
      o0 = oq.size();
      h0 = hq.size();
      send(32'hAABBCCDD, 4'hF, 1'b0, 2'd2, "rf_p1b0");
      send(32'h11220000, 4'hC, 1'b1, 2'd2, "rf_p1b1");
      repeat (4) @(negedge clk);
      n_checks++;
      if (oq.size() - o0 != 1 || oget(o0) !== {32'hCCDD1122, 4'hF, 1'b1}) begin
         n_fail++;
         $display("FAIL rf_after_out: got %h (n=%0d) want CCDD1122F1", oget(o0), oq.size() - o0);
      end
      n_checks++;
      if (hq.size() - h0 != 1 || hget(h0) !== {32'hAABB0000, 4'hC}) begin
         n_fail++;
         $display("FAIL rf_after_hdr: got %h (n=%0d) want AABB0000C", hget(h0), hq.size() - h0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_s1_flush();
      test_s2_fold();
      test_short();
      test_s0_pass();
      test_stall();
      test_back_to_back();
      test_reset_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
